// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle-latency reads to
// port A, buffers returned words in a small prefetch FIFO and hands inst/PC
// pairs to decode over valid/ready. A response arriving into an empty FIFO is
// forwarded straight to the head so a redirect costs exactly two bubbles.
module if_prefetch_unit #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_en,
    output logic [ADDR_WIDTH-1:0]         imem_addr,
    input  logic [DATA_WIDTH-1:0]         inst,
    input  logic [DATA_WIDTH-1:0]         T_m,
    output logic [DATA_WIDTH-1:0]         T_m_o,
    input  logic                          jump_flag,
    input  logic [ADDR_WIDTH-1:0]         jump_target,
    input  logic                          halt,
    input  logic                          inst_ready,
    output logic                          inst_valid,
    output logic [DATA_WIDTH-1:0]         inst_out,
    output logic [ADDR_WIDTH-1:0]         inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_REDIR = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  infl_q, infl_d;
    logic [ADDR_WIDTH-1:0] infl_pc_q, infl_pc_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [DATA_WIDTH-1:0] buf_inst [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc   [FIFO_DEPTH];

    logic          fifo_empty, bypass, push, pop_fifo, wr_en;
    logic [CW:0]   occ;

    assign T_m_o      = T_m;
    assign imem_addr  = fetch_pc_q;
    assign fifo_count = count_q;

    // Head selection, issue decision and next-state computation
    always_comb begin
        fifo_empty = (count_q == '0);
        occ        = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
        imem_en    = !rst && (state_q == ST_RUN) && !jump_flag && !halt &&
                     (occ < (CW+1)'(FIFO_DEPTH));

        inst_valid = !fifo_empty || infl_q;
        inst_out   = '0;
        inst_pc    = '0;
        if (!fifo_empty) begin
            inst_out = buf_inst[rd_ptr_q];
            inst_pc  = buf_pc[rd_ptr_q];
        end else if (infl_q) begin
            inst_out = inst;
            inst_pc  = infl_pc_q;
        end

        // An arriving word consumed the same cycle never touches the FIFO.
        bypass   = fifo_empty && infl_q && inst_ready;
        push     = infl_q && !bypass;
        pop_fifo = !fifo_empty && inst_ready;
        wr_en    = push && !jump_flag;

        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(imem_en);
        infl_d     = imem_en;
        infl_pc_d  = imem_en ? fetch_pc_q : infl_pc_q;
        rd_ptr_d   = rd_ptr_q + PW'(pop_fifo);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        count_d    = count_q + CW'(push) - CW'(pop_fifo);

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (halt) state_d = ST_HALT;
            ST_REDIR: state_d = halt ? ST_HALT : ST_RUN;
            ST_HALT:  if (!halt) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        // Redirect from any state: flush buffered and in-flight words.
        if (jump_flag) begin
            state_d    = ST_REDIR;
            fetch_pc_d = jump_target;
            infl_d     = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RST_PC;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            infl_q     <= infl_d;
            infl_pc_q  <= infl_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_inst[wr_ptr_q] <= inst;
            buf_pc[wr_ptr_q]   <= infl_pc_q;
        end
    end
endmodule
